uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
- Parametrised oversampling UART receiver. Successor to the fixed 8x, 8-bit, no-reset receiver.
- Adds:
  - a programmable baud divider, so it runs on the system clock;
  - configurable oversampling, data width, parity and stop bits;
  - 3-sample majority voting and false-start rejection;
  - parity and framing error flags;
  - a valid/ready output with overrun detection.
- Sits between the pad-side serial input and byte consumers (SPI bridge, FIFOs).

Parameters:
- CLK_DIV, 4: system clocks per oversample tick (≥1).
- OVERSAMPLE, 8: ticks per bit; legal values 8 or 16.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_rx  in  1  asynchronous serial line, idle high.
- m_data  out  DATA_BITS  received word, LSB = first data bit on the wire.
- m_valid  out  1  m_data and flags are valid.
- m_ready  in  1  consumer accepts the word when m_valid && m_ready.
- parity_err  out  1  qualifies m_data; 0 when PARITY = 0.
- frame_err  out  1  qualifies m_data; a stop bit was sampled low.
- overrun  out  1  one-cycle pulse: a frame was dropped.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: asynchronous, active-low; one clock clk.
  - Every output and register is 0 during reset, except the uart_rx synchroniser flops, which reset to 1.
  - Asserting reset mid-frame discards the frame; no output results.
- Input: 2-FF synchroniser; rx_s is the synchronised line.
- Tick generator:
  - Counter runs 0..CLK_DIV-1; tick = (cnt == CLK_DIV-1).
  - Counter is cleared when a start edge is detected in IDLE, so all bits are phase-aligned to that edge.
- Sample counter: s, 0..OVERSAMPLE-1, advanced on each tick in non-IDLE states.
- Bit decision: majority of rx_s at s = M-1, M, M+1, where M = OVERSAMPLE/2. The decision is registered at s = M+1.
- Bit end: each bit ends at s = OVERSAMPLE-1, when s wraps to 0.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
  - IDLE:
    - On rx_s == 0 → START, s = 0, tick counter cleared.
  - START:
    - At the decision point, a voted 1 is a false start → IDLE.
    - At bit end → DATA with bit index 0.
  - DATA:
    - The voted bit is shifted in LSB-first.
    - After DATA_BITS bit ends → PAR if PARITY != 0, else STOP.
  - PAR:
    - The voted bit is checked against the XOR of the data bits. Odd parity means the total count of ones, parity bit included, is odd.
  - STOP:
    - Each stop bit is judged at its decision point; any voted 0 sets frame_err.
    - The frame completes at the decision point of the last stop bit, not at its bit end, so back-to-back frames resync.
    - If any stop bit was 0 → WAIT_IDLE, else → IDLE.
  - WAIT_IDLE:
    - Stays until rx_s == 1 for one full tick, then → IDLE. This handles break and noise without a spurious restart.
- Output register:
  - On frame completion, if m_valid == 0 or (m_valid && m_ready) in the same cycle:
    - load m_data, parity_err and frame_err;
    - m_valid = 1 on the next clk edge.
  - Otherwise, the new frame is dropped, m_data is held, and overrun pulses for 1 clk.
  - m_valid clears on m_valid && m_ready when no load occurs in the same cycle.
  - Outputs stay stable while m_valid && !m_ready.
- Latency: m_valid rises 1 clk after the last stop-bit decision tick.
- Framing error: data with frame_err = 1 is still delivered; the consumer decides.

Decomposition:
- Shared package uart_pkg holds:
  - the parity encodings PAR_NONE, PAR_ODD, PAR_EVEN;
  - the rx FSM state enum;
  - the function parity_calc(data, mode).
- Sub-module uart_os_tick (parameter CLK_DIV; ports clk, rst_n, clr, tick). It is shared with the future transmitter.

Test Plan:
- CLK_DIV = 4, OVERSAMPLE = 8, 8N1; send 0xA5 at 32 clk/bit, m_ready = 1:
  - m_data = 0xA5, m_valid is a 1-clk pulse, no errors;
  - m_valid rises 1 clk after the stop-bit decision tick.
- uart_rx low for 2 ticks only (glitch):
  - no m_valid;
  - busy returns to 0 by the START decision point;
  - a following 0x3C is received correctly.
- PARITY = 2, send 0x37 with the parity bit inverted → m_data = 0x37, parity_err = 1. Resend with the correct parity bit → parity_err = 0.
- Stop bit driven low, line held low 3 bit-times, then 0x5A sent:
  - first word has frame_err = 1;
  - no frame is started during the low period;
  - 0x5A is received with frame_err = 0.
- m_ready = 0, send 0x11 then 0x22 → m_data stays 0x11, overrun pulses once. Raising m_ready → handshake completes and m_valid drops.
- rst_n asserted in the middle of DATA bit 3 and released, then 0xC3 sent:
  - no output from the aborted frame;
  - 0xC3 is received exactly once.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state encoding and
// the parity helper used by both the receiver and the future transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Returns the parity bit the transmitter should send for `data` (unused
  // upper bits must be zero). Odd: total ones including this bit is odd.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input int                       mode);
    case (mode)
      PAR_ODD:  return ~(^data);
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV system clocks,
// restartable so the bit grid can be phase-aligned to a start edge.
module uart_os_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority voting, false-start rejection,
// parity/framing checks and a valid/ready output stage with overrun flag.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATA_BITS);

  localparam logic [SW-1:0]  S_PRE   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]  S_MID   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0]  S_DEC   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0]  S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(DATA_BITS - 1);
  localparam logic           SI_LAST = 1'(STOP_BITS - 1);

  rx_state_e state, state_d;

  logic                 rx_meta, rx_s;
  logic                 tick, tick_clr;
  logic [SW-1:0]        s_cnt;
  logic [BIW-1:0]       bit_idx;
  logic                 stop_idx;
  logic [1:0]           samp;
  logic                 vote;
  logic                 dec, bit_end;
  logic [DATA_BITS-1:0] shreg;
  logic [MAX_DATA_BITS-1:0] data_ext;
  logic                 par_err_r, frm_err_r;
  logic                 line_hi;
  logic                 frame_done, load;

  // The synchroniser resets to the idle line level so reset release never
  // looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  uart_os_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  assign dec     = tick && (s_cnt == S_DEC);
  assign bit_end = tick && (s_cnt == S_LAST);
  assign vote    = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);
  assign busy    = (state != IDLE);
  assign load    = frame_done && (!m_valid || m_ready);

  always_comb begin
    data_ext                   = '0;
    data_ext[DATA_BITS-1:0]    = shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    tick_clr   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d  = START;
          tick_clr = 1'b1;
        end
      end
      START: begin
        if (dec && vote) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_idx == BI_LAST)) begin
          state_d = (PARITY != PAR_NONE) ? PAR : STOP;
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Completing at the decision point leaves half a bit to catch the
        // next start edge of a back-to-back frame.
        if (dec && (stop_idx == SI_LAST)) begin
          frame_done = 1'b1;
          state_d    = (frm_err_r || !vote) ? WAIT_IDLE : IDLE;
        end
      end
      WAIT_IDLE: begin
        if (tick && line_hi && rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the shift register and error flags are reset along with the control
  // state, so m_data never carries X even before the first frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      samp      <= '0;
      shreg     <= '0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      line_hi   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        s_cnt <= '0;
      end else if (tick) begin
        s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
      end

      if (tick && (s_cnt == S_PRE)) samp[0] <= rx_s;
      if (tick && (s_cnt == S_MID)) samp[1] <= rx_s;

      if (state == START) begin
        bit_idx   <= '0;
        par_err_r <= 1'b0;
        frm_err_r <= 1'b0;
      end else if ((state == DATA) && bit_end) begin
        bit_idx <= bit_idx + BIW'(1);
      end

      if ((state == DATA) && dec) begin
        shreg <= {vote, shreg[DATA_BITS-1:1]};
      end

      if ((state == PAR) && dec) begin
        par_err_r <= (vote != parity_calc(data_ext, PARITY));
      end

      if (state != STOP) begin
        stop_idx <= 1'b0;
      end else begin
        if (dec && !vote) frm_err_r <= 1'b1;
        if (bit_end) stop_idx <= 1'b1;
      end

      // Exit from WAIT_IDLE needs the line high across one whole tick period.
      if ((state != WAIT_IDLE) || !rx_s) begin
        line_hi <= 1'b0;
      end else if (tick) begin
        line_hi <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= frame_done && !load;
      if (load) begin
        m_data     <= shreg;
        parity_err <= par_err_r;
        frame_err  <= frm_err_r || !vote;
        m_valid    <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
